icache_line_filler: RTL and testbench

- Memory-side responder for the instruction cache's line-miss requests.
- Accepts a block-aligned line address from the cache.
- Streams 16 byte reads to the byte-wide main RAM port and assembles them into a 128-bit line.
- Returns the line to the cache with a one-cycle valid pulse. Sits between the instruction cache and the RAM/memory arbiter.

---
 rtl/icache_line_filler_pkg.sv | 19 +
 rtl/icache_line_filler.sv | 108 ++++++++++
 tb/tb_icache_line_filler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_line_filler_pkg.sv
// Shared definitions for the instruction-cache line filler, cache and memory arbiter.
package icache_line_filler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_e;

  // Bytes per cache line for a given log2 block size.
  function automatic int unsigned line_bytes(input int unsigned block_width);
    return 32'(1) << block_width;
  endfunction

  localparam int unsigned BLOCK_WIDTH_DEF = 4;
  localparam int unsigned LINE_BYTES      = line_bytes(BLOCK_WIDTH_DEF);
  localparam int unsigned RAM_RD_LATENCY  = 1;

endpackage

// File: rtl/icache_line_filler.sv
// Fetches one aligned cache line from byte-wide RAM and returns it to the icache
// with a one-cycle valid pulse.
module icache_line_filler
  import icache_line_filler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned BLOCK_WIDTH = 4,
  parameter int unsigned LINE_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  line_valid,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din
);

  localparam int unsigned NBYTES = line_bytes(BLOCK_WIDTH);
  localparam int unsigned CW     = BLOCK_WIDTH + 1;

  fill_state_e                 state, state_d;
  logic [ADDR_WIDTH-1:0]       base;
  logic [CW-1:0]               issue_cnt;
  logic [BLOCK_WIDTH-1:0]      recv_cnt;
  logic                        issued_q;
  logic [RAM_RD_LATENCY-1:0]   rd_pipe;
  logic                        accept_c;
  logic                        issue_c;
  logic                        capture_c;

  assign mem_wr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state plus the accept / issue / capture strobes; flush overrides everything.
  always_comb begin
    state_d   = state;
    accept_c  = 1'b0;
    issue_c   = 1'b0;
    capture_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && rdy) begin
          accept_c = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue_c   = rdy && (issue_cnt < CW'(NBYTES));
        capture_c = rd_pipe[RAM_RD_LATENCY-1];
        if (capture_c && (recv_cnt == BLOCK_WIDTH'(NBYTES - 1))) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      accept_c  = 1'b0;
      issue_c   = 1'b0;
      capture_c = 1'b0;
    end
  end

  // Issue counter, RAM address, read-latency tracking and byte-lane assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      line_valid <= 1'b0;
      line_data  <= '0;
      mem_a      <= '0;
      base       <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      issued_q   <= 1'b0;
      rd_pipe    <= '0;
    end else begin
      req_ready  <= (state_d == ST_IDLE);
      line_valid <= (state_d == ST_DONE);
      issued_q   <= issue_c;
      // Capture strobe trails the issue by the RAM read latency.
      if (flush) rd_pipe <= '0;
      else       rd_pipe <= (rd_pipe << 1) | RAM_RD_LATENCY'(issued_q);
      if (accept_c) begin
        base      <= req_addr & ~ADDR_WIDTH'(NBYTES - 1);
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
      if (issue_c) begin
        mem_a     <= base + ADDR_WIDTH'(issue_cnt);
        issue_cnt <= issue_cnt + CW'(1);
      end
      if (capture_c) begin
        line_data[{recv_cnt, 3'd0} +: 8] <= mem_din;
        recv_cnt                         <= recv_cnt + BLOCK_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_line_filler.sv
// Directed bench for icache_line_filler against a one-cycle-latency RAM returning a[7:0].
module tb_icache_line_filler;
  import icache_line_filler_pkg::*;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic          flush;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          line_valid;
  logic [127:0]  line_data;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic [7:0]    mem_din;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // RAM: address registered at the edge, byte visible the following cycle.
  always @(posedge clk) mem_din <= mem_a[7:0];

  icache_line_filler #(
    .ADDR_WIDTH (17),
    .BLOCK_WIDTH(4),
    .LINE_WIDTH (128)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .line_valid(line_valid),
    .line_data (line_data),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din)
  );

  // One full fill; cycle 0 is the first cycle after the accepting edge.
  task automatic run_fill(input logic [AW-1:0] addr, input int stall_from, input int stall_len,
                          input logic hold, input logic [AW-1:0] hold_addr,
                          input logic [127:0] exp_line, input string name);
    logic [AW-1:0] base;
    int            issued;
    int            lv_cyc;
    base   = addr & ~AW'(LINE_BYTES - 1);
    lv_cyc = 18 + stall_len;
    rdy       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk); #1;
    if (hold) req_addr = hold_addr;
    else      req_valid = 1'b0;
    issued = 0;
    for (int c = 0; c <= lv_cyc + 1; c++) begin
      rdy = !(c >= stall_from && c < stall_from + stall_len);
      if (issued > 0) begin
        vectors++;
        if (mem_a !== base + AW'(issued - 1)) begin
          errors++;
          $display("FAIL %s mem_a cycle %0d: got %h expected %h", name, c, mem_a, base + AW'(issued - 1));
        end
      end
      vectors++;
      if (line_valid !== (c == lv_cyc)) begin
        errors++;
        $display("FAIL %s line_valid cycle %0d: got %b expected %b", name, c, line_valid, (c == lv_cyc));
      end
      vectors++;
      if (req_ready !== (c == lv_cyc + 1)) begin
        errors++;
        $display("FAIL %s req_ready cycle %0d: got %b expected %b", name, c, req_ready, (c == lv_cyc + 1));
      end
      if (c == lv_cyc) begin
        vectors++;
        if (line_data !== exp_line) begin
          errors++;
          $display("FAIL %s line_data: got %h expected %h", name, line_data, exp_line);
        end
        vectors++;
        if (mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL %s mem_wr: got %b expected 0", name, mem_wr);
        end
      end
      if (c != lv_cyc + 1) begin
        @(posedge clk); #1;
        if (rdy && issued < 16) issued++;
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
    #12;
    vectors++;
    if (req_ready !== 1'b1 || line_valid !== 1'b0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: got rr=%b lv=%b wr=%b expected 1 0 0", req_ready, line_valid, mem_wr);
    end
    vectors++;
    if (mem_a !== '0 || line_data !== '0) begin
      errors++;
      $display("FAIL reset data: got mem_a=%h line=%h expected 0 0", mem_a, line_data);
    end
    @(negedge clk); rst_n = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_fill();
    run_fill(17'h00123, 0, 0, 1'b0, '0, 128'h2F2E2D2C2B2A29282726252423222120, "basic");
  endtask

  task automatic test_rdy_stall();
    run_fill(17'h00400, 5, 3, 1'b0, '0, 128'h0F0E0D0C0B0A09080706050403020100, "stall");
  endtask

  task automatic test_flush();
    rdy = 1'b1; req_valid = 1'b1; req_addr = 17'h00300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush req_ready: got %b expected 1", req_ready);
    end
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (line_valid !== 1'b0 || mem_a !== 17'h00308) begin
        errors++;
        $display("FAIL flush idle cycle %0d: got lv=%b mem_a=%h expected 0 00308", c, line_valid, mem_a);
      end
      @(posedge clk); #1;
    end
    // Flush wins over a simultaneous request.
    req_valid = 1'b1; req_addr = 17'h00600; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (req_ready !== 1'b1 || mem_a !== 17'h00308) begin
        errors++;
        $display("FAIL flush_vs_accept cycle %0d: got rr=%b mem_a=%h expected 1 00308", c, req_ready, mem_a);
      end
      @(posedge clk); #1;
    end
    run_fill(17'h00800, 0, 0, 1'b0, '0, 128'h0F0E0D0C0B0A09080706050403020100, "after_flush");
  endtask

  task automatic test_back_to_back();
    run_fill(17'h00010, 0, 0, 1'b1, 17'h00040, 128'h1F1E1D1C1B1A19181716151413121110, "busy_first");
    run_fill(17'h00040, 0, 0, 1'b0, '0, 128'h4F4E4D4C4B4A49484746454443424140, "busy_second");
  endtask

  task automatic test_top_wrap();
    run_fill(17'h1FFF5, 0, 0, 1'b0, '0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, "wrap");
  endtask

  task automatic test_async_reset();
    rdy = 1'b1; req_valid = 1'b1; req_addr = 17'h00500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_a !== '0 || line_data !== '0) begin
      errors++;
      $display("FAIL async_reset data: got mem_a=%h line=%h expected 0 0", mem_a, line_data);
    end
    vectors++;
    if (req_ready !== 1'b1 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ctrl: got rr=%b lv=%b expected 1 0", req_ready, line_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset release req_ready: got %b expected 1", req_ready);
    end
    run_fill(17'h00123, 0, 0, 1'b0, '0, 128'h2F2E2D2C2B2A29282726252423222120, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_rdy_stall();
    test_flush();
    test_back_to_back();
    test_top_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
